hub75_rx: RTL and testbench
===========================

# hub75_rx

Receive-side model of the 32×16, 1/8-scan HUB75 panel stream produced by the team's display drivers. It samples the shift clock, RGB, latch, OE and ABC lines, reconstructs the shifted row data and commits it into an internal 16-row framebuffer on every latch. It provides a registered pixel read port, per-row/frame strobes and protocol error flags. It sits at the far end of the panel cable, both as a synthesizable loopback checker on the FPGA and as the scoreboard front-end in driver benches.

## Interface
- WIDTH, 32, columns per row (shift-register depth)
- ROWS, 8, scan rows addressed by ABC; framebuffer holds 2*ROWS rows
- clk  in  1  system clock; must be ≥4× the sclk frequency
- reset  in  1  asynchronous, active-high
- sclk  in  1  panel shift clock (driver's outclk), asynchronous to clk
- rgb  in  6  {R1,G1,B1,R2,G2,B2}; R1..B1 top half, R2..B2 bottom half
- lat  in  1  latch, commit on rising edge
- oe  in  1  output enable, active-low (high = blanked)
- abc  in  $clog2(ROWS)  scan row address
- rd_row  in  $clog2(2*ROWS)  read row (0..15)
- rd_col  in  $clog2(WIDTH)  read column (0..31)
- rd_pix  out  3  {R,G,B} at (rd_row, rd_col), registered
- row_valid  out  1  one-cycle pulse per commit
- row_addr  out  $clog2(ROWS)  ABC value of the last commit, held
- frame_done  out  1  one-cycle pulse on commit of row ROWS-1
- short_row  out  1  one-cycle pulse on a commit with fewer than WIDTH shifts
- ontime  out  16  clk cycles of oe low in the last completed row period

## Operation
- sclk, lat, oe, rgb and abc each pass through an identical 2-flop synchronizer, so all stay mutually aligned. Rising edges of synced sclk and lat are detected by comparison with a third stage.
- On an sclk edge: shift the 6-bit rgb into two WIDTH×3 shift registers (top, bottom). Increment shift_cnt, saturating at WIDTH.
- On a lat edge: commit. Write top shift register to row abc and bottom to row abc+ROWS. Pulse row_valid, load row_addr=abc, pulse short_row if shift_cnt<WIDTH, and pulse frame_done if abc==ROWS-1. Then clear both shift registers and shift_cnt.
- Column mapping at commit: the last pixel shifted is column 0; the pixel shifted k edges before it is column k. Pixels older than WIDTH edges are discarded. Columns never shifted since the previous commit read 0.
- Simultaneous sclk and lat edge: the shift is applied first, and the commit includes the new pixel.
- Read: rd_pix <= fb[rd_row][rd_col] every clk. A read of the row being committed in the same cycle returns the old data.
- Reset (any time, including mid-row): clears the synchronizers, shift registers, shift_cnt, the framebuffer and all outputs to 0. The first sclk/lat edge after reset is not detected spuriously because the edge-detect stages also reset to 0.

## Timing
- Input pin to internal edge: 3 clk cycles.
- Commit: row_valid, frame_done, short_row and row_addr are registered in the cycle after the lat edge is detected. The framebuffer is updated in that same cycle. A read issued in the following cycle sees the new data.
- rd_pix latency: 1 cycle.
- Strobes are exactly 1 cycle wide. Back-to-back latches must be ≥2 clk apart, which is guaranteed by the sclk ratio.
- All outputs reset to 0.

## Configuration
- HUB75_RX_ONTIME_EN defined: a 16-bit counter increments each clk while synced oe==0, saturating at 16'hFFFF. At each commit it is copied to ontime and cleared.
- HUB75_RX_ONTIME_EN undefined: no counter is built, and ontime is tied to 0.

## Structure
- Package hub75_pkg holds:
  - WIDTH and ROWS defaults
  - pixel_t (3-bit {r,g,b})
  - rgb_pair_t ({pixel_t top, pixel_t bot})
  - row_t (pixel_t [WIDTH-1:0])
- Sub-module hub75_sync_edge: 2-flop synchronizer plus rising-edge detect with async reset. It is instantiated for sclk and lat, and used in sync-only form for oe, rgb and abc.

## Test plan
- Reset, then read all 16×32 addresses -> rd_pix=0; row_valid, frame_done, short_row and ontime all 0.
- Shift 32 pixels with only the first = rgb 6'b100_001, then latch with abc=3 -> row_valid pulse, row_addr=3, short_row=0. Read (3,31)=3'b100, (11,31)=3'b001; all other pixels in rows 3 and 11 are 0.
- Shift 36 pixels (driver pattern: 0..31 then 4 zeros) with pixel 0 green, then latch -> column 35-0 is dropped. Pixel 4 appears at column 31 and pixel 35 at column 0.
- Shift 20 pixels of 6'b111_111, then latch with abc=5 -> short_row pulse. Row 5, columns 0..19 = 3'b111; columns 20..31 = 0.
- Latch abc=0..7 in order -> eight row_valid pulses and exactly one frame_done, on the abc=7 commit.
- With HUB75_RX_ONTIME_EN, hold oe low 100 clk between latches -> ontime=100 after the next commit. Assert reset after 10 shifts -> the next 32-shift row commits cleanly and short_row=0.

Source files
------------

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and defaults for the HUB75 receive-side model.
//   DEF_WIDTH  columns per row (shift-register depth)
//   DEF_ROWS   scan rows addressed by ABC (framebuffer holds 2*DEF_ROWS)
//   pixel_t    {r,g,b}
//   rgb_pair_t {top, bot} as presented on the rgb pins {R1,G1,B1,R2,G2,B2}
//   row_t      one framebuffer row at the default width
package hub75_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_ROWS  = 8;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } pixel_t;

    typedef struct packed {
        pixel_t top;
        pixel_t bot;
    } rgb_pair_t;

    typedef pixel_t [DEF_WIDTH-1:0] row_t;

endpackage

// File: rtl/hub75_sync_edge.sv
// hub75_sync_edge: W-bit 2-flop synchronizer with optional rising-edge detect.
//   clk    system clock
//   reset  asynchronous, active-high; clears every stage
//   d      asynchronous inputs
//   q      synchronized inputs (2 flops)
//   rise   per-bit rising edge of q (EDGE=1), constant 0 when EDGE=0
// With EDGE=0 no third stage is built (sync-only form).
module hub75_sync_edge #(
    parameter int unsigned W    = 1,
    parameter bit          EDGE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise
);

    logic [W-1:0] s1;
    logic [W-1:0] s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

    generate
        if (EDGE) begin : g_edge
            logic [W-1:0] s3;

            // Third stage resets to 0 so an input already high at reset
            // release reads as one edge, never a spurious repeat.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) s3 <= '0;
                else       s3 <= s2;
            end

            assign rise = s2 & ~s3;
        end else begin : g_no_edge
            assign rise = '0;
        end
    endgenerate

endmodule

// File: rtl/hub75_rx.sv
// hub75_rx: receive-side model of a 1/N-scan HUB75 panel stream.
// Samples sclk/rgb/lat/oe/abc, rebuilds each shifted row and commits it into
// a 2*ROWS x WIDTH framebuffer on every rising edge of lat.
//   clk, reset        system clock (>= 4x sclk), async active-high reset
//   sclk, rgb         shift clock and {R1,G1,B1,R2,G2,B2} data
//   lat, oe, abc      latch (commit), active-low enable, scan row address
//   rd_row, rd_col    framebuffer read address; rd_pix returned 1 clk later
//   row_valid         1-clk pulse per commit; row_addr holds its abc
//   frame_done        1-clk pulse on commit of row ROWS-1
//   short_row         1-clk pulse on commit with fewer than WIDTH shifts
//   ontime            oe-low clk count of the last row period
// Build option: define HUB75_RX_ONTIME_EN to build the ontime counter;
// otherwise ontime is tied to 0.
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ROWS  = DEF_ROWS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sclk,
    input  logic [5:0]                rgb,
    input  logic                      lat,
    input  logic                      oe,
    input  logic [$clog2(ROWS)-1:0]   abc,
    input  logic [$clog2(2*ROWS)-1:0] rd_row,
    input  logic [$clog2(WIDTH)-1:0]  rd_col,
    output logic [2:0]                rd_pix,
    output logic                      row_valid,
    output logic [$clog2(ROWS)-1:0]   row_addr,
    output logic                      frame_done,
    output logic                      short_row,
    output logic [15:0]               ontime
);

    localparam int unsigned AW = $clog2(ROWS);
    localparam int unsigned RW = $clog2(2*ROWS);
    localparam int unsigned CW = $clog2(WIDTH+1);
    localparam int unsigned DW = 1 + 6 + AW;

    typedef pixel_t [WIDTH-1:0] line_t;

    // Synchronizers: every input sees the same 2-flop delay, so rgb/abc/oe
    // stay aligned with the sclk/lat edges derived from them.
    logic [1:0]    edge_unused_q;
    logic [1:0]    edge_rise;
    logic [DW-1:0] dat_q;
    logic [DW-1:0] dat_unused_rise;

    hub75_sync_edge #(
        .W    (2),
        .EDGE (1'b1)
    ) u_sync_edge (
        .clk   (clk),
        .reset (reset),
        .d     ({sclk, lat}),
        .q     (edge_unused_q),
        .rise  (edge_rise)
    );

    hub75_sync_edge #(
        .W    (DW),
        .EDGE (1'b0)
    ) u_sync_dat (
        .clk   (clk),
        .reset (reset),
        .d     ({oe, rgb, abc}),
        .q     (dat_q),
        .rise  (dat_unused_rise)
    );

    logic          sclk_rise;
    logic          lat_rise;
    logic          oe_s;
    rgb_pair_t     rgb_s;
    logic [AW-1:0] abc_s;

    assign sclk_rise             = edge_rise[1];
    assign lat_rise              = edge_rise[0];
    assign {oe_s, rgb_s, abc_s}  = dat_q;

    // Shift state
    line_t         sh_top;
    line_t         sh_bot;
    logic [CW-1:0] cnt;
    line_t         top_n;
    line_t         bot_n;
    logic [CW-1:0] cnt_n;

    // Shift is resolved first so a commit on the same cycle includes the new
    // pixel. Newest pixel enters at column 0; older ones move up and fall off
    // past column WIDTH-1.
    always_comb begin
        top_n = sh_top;
        bot_n = sh_bot;
        cnt_n = cnt;
        if (sclk_rise) begin
            top_n = {sh_top[WIDTH-2:0], rgb_s.top};
            bot_n = {sh_bot[WIDTH-2:0], rgb_s.bot};
            if (cnt != CW'(WIDTH)) cnt_n = cnt + 1'b1;
        end
    end

    logic [RW-1:0] top_idx;
    logic [RW-1:0] bot_idx;

    assign top_idx = RW'(abc_s);
    assign bot_idx = RW'(abc_s) + RW'(ROWS);

    line_t fb [2*ROWS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_top     <= '0;
            sh_bot     <= '0;
            cnt        <= '0;
            rd_pix     <= '0;
            row_valid  <= 1'b0;
            row_addr   <= '0;
            frame_done <= 1'b0;
            short_row  <= 1'b0;
            for (int unsigned i = 0; i < 2*ROWS; i++) fb[i] <= '0;
        end else begin
            row_valid  <= 1'b0;
            frame_done <= 1'b0;
            short_row  <= 1'b0;
            rd_pix     <= fb[rd_row][rd_col];
            if (lat_rise) begin
                fb[top_idx] <= top_n;
                fb[bot_idx] <= bot_n;
                row_valid   <= 1'b1;
                row_addr    <= abc_s;
                short_row   <= (cnt_n < CW'(WIDTH));
                frame_done  <= (abc_s == AW'(ROWS-1));
                sh_top      <= '0;
                sh_bot      <= '0;
                cnt         <= '0;
            end else begin
                sh_top <= top_n;
                sh_bot <= bot_n;
                cnt    <= cnt_n;
            end
        end
    end

`ifdef HUB75_RX_ONTIME_EN
    logic [15:0] on_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            on_cnt <= '0;
            ontime <= '0;
        end else if (lat_rise) begin
            ontime <= on_cnt;
            on_cnt <= '0;
        end else if (!oe_s && (on_cnt != '1)) begin
            on_cnt <= on_cnt + 1'b1;
        end
    end
`else
    logic unused_oe;

    assign unused_oe = oe_s;
    assign ontime    = '0;
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: randomized scoreboard bench for hub75_rx.
// Stimulus tasks drive the panel pins and push expected commits and read
// results into queues; an independent monitor pops and compares whenever the
// DUT presents row_valid or a read result.
module tb_hub75_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic [5:0]  rgb;
    logic        lat;
    logic        oe;
    logic [2:0]  abc;
    logic [3:0]  rd_row;
    logic [4:0]  rd_col;
    logic [2:0]  rd_pix;
    logic        row_valid;
    logic [2:0]  row_addr;
    logic        frame_done;
    logic        short_row;
    logic [15:0] ontime;

    hub75_rx #(
        .WIDTH (32),
        .ROWS  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sclk       (sclk),
        .rgb        (rgb),
        .lat        (lat),
        .oe         (oe),
        .abc        (abc),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_pix     (rd_pix),
        .row_valid  (row_valid),
        .row_addr   (row_addr),
        .frame_done (frame_done),
        .short_row  (short_row),
        .ontime     (ontime)
    );

    always #5 clk = ~clk;

`ifdef HUB75_RX_ONTIME_EN
    localparam bit ON_EN = 1'b1;
`else
    localparam bit ON_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, int unsigned act, int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned addr;
        int unsigned short_r;
        int unsigned frame;
        int unsigned on;
    } commit_t;

    logic [5:0]  pend[$];          // pixels shifted since the last commit, oldest first
    logic [2:0]  mfb[16][32];
    commit_t     cq[$];
    logic [2:0]  rq[$];
    int unsigned on_model;

    function automatic void model_reset();
        pend.delete();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 32; c++)
                mfb[r][c] = 3'b000;
        on_model = 0;
    endfunction

    function automatic void model_commit(input int unsigned a);
        commit_t     e;
        int unsigned n;
        logic [5:0]  pix;
        n = pend.size();
        for (int unsigned c = 0; c < 32; c++) begin
            pix = (c < n) ? pend[n-1-c] : 6'b0;
            mfb[a][c]   = pix[5:3];
            mfb[a+8][c] = pix[2:0];
        end
        e.addr    = a;
        e.short_r = (n < 32) ? 1 : 0;
        e.frame   = (a == 7) ? 1 : 0;
        e.on      = ON_EN ? on_model : 0;
        cq.push_back(e);
        on_model = 0;
        pend.delete();
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic shift_px(input logic [5:0] v);
        @(negedge clk);
        rgb = v;
        repeat (2) @(negedge clk);
        sclk = 1'b1;
        pend.push_back(v);
        repeat (2) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic do_latch(input logic [2:0] a, input bit with_shift, input logic [5:0] v);
        @(negedge clk);
        abc = a;
        if (with_shift) rgb = v;
        repeat (2) @(negedge clk);
        lat = 1'b1;
        if (with_shift) begin
            sclk = 1'b1;
            pend.push_back(v);
        end
        model_commit(a);
        repeat (2) @(negedge clk);
        lat  = 1'b0;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    logic rd_req   = 1'b0;
    logic rd_req_d = 1'b0;

    task automatic rd(input int r, input int c);
        @(negedge clk);
        rd_row = 4'(r);
        rd_col = 5'(c);
        rd_req = 1'b1;
        rq.push_back(mfb[r][c]);
    endtask

    task automatic rd_end();
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic read_row(input int r);
        for (int c = 0; c < 32; c++) rd(r, c);
        rd_end();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_row_valid"},  row_valid,  0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_short_row"},  short_row,  0);
        check({tag, "_row_addr"},   row_addr,   0);
        check({tag, "_ontime"},     ontime,     0);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) rd_req_d <= rd_req;

    always @(negedge clk) begin
        if (!reset) begin
            if (rd_req_d) begin
                if (rq.size() == 0) check("rd_queue_underflow", 1, 0);
                else                check("rd_pix", rd_pix, rq.pop_front());
            end
            if (row_valid) begin
                if (cq.size() == 0) begin
                    check("unexpected_row_valid", 1, 0);
                end else begin
                    commit_t e;
                    e = cq.pop_front();
                    check("row_addr",   row_addr,   e.addr);
                    check("short_row",  short_row,  e.short_r);
                    check("frame_done", frame_done, e.frame);
                    check("ontime",     ontime,     e.on);
                end
            end else begin
                check("stray_strobe", {frame_done, short_row}, 0);
            end
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        reset  = 1'b1;
        sclk   = 1'b0;
        lat    = 1'b0;
        oe     = 1'b1;
        rgb    = '0;
        abc    = '0;
        rd_row = '0;
        rd_col = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        for (int r = 0; r < 16; r++) read_row(r);

        // Single marker pixel shifted first, 32 shifts total
        shift_px(6'b100_001);
        for (int i = 1; i < 32; i++) shift_px(6'b000_000);
        do_latch(3'd3, 1'b0, 6'b0);
        read_row(3);
        read_row(11);

        // 36 shifts: oldest 4 pixels fall off the far end
        for (int i = 0; i < 36; i++) begin
            if (i == 0)      shift_px(6'b010_000);
            else if (i < 32) shift_px(6'($urandom));
            else             shift_px(6'b000_000);
        end
        do_latch(3'd1, 1'b0, 6'b0);
        read_row(1);
        read_row(9);

        // Short row: 20 white pixels
        for (int i = 0; i < 20; i++) shift_px(6'b111_111);
        do_latch(3'd5, 1'b0, 6'b0);
        read_row(5);
        read_row(13);

        // Shift and latch on the same edge: 31 + 1 = full row
        for (int i = 0; i < 31; i++) shift_px(6'($urandom));
        do_latch(3'd2, 1'b1, 6'($urandom));
        read_row(2);
        read_row(10);

        // Full frame of rows 0..7, a few pixels each
        for (int a = 0; a < 8; a++) begin
            int n;
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) shift_px(6'($urandom));
            do_latch(3'(a), 1'b0, 6'b0);
        end
        for (int i = 0; i < 20; i++) rd($urandom_range(0, 15), $urandom_range(0, 31));
        rd_end();

        // Random rows of random length and address
        for (int k = 0; k < 10; k++) begin
            int n;
            n = $urandom_range(0, 40);
            for (int i = 0; i < n; i++) shift_px(6'($urandom));
            do_latch(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 6'($urandom));
            for (int i = 0; i < 12; i++) rd($urandom_range(0, 15), $urandom_range(0, 31));
            rd_end();
        end

        // oe low for exactly 100 clk inside one row period
        @(negedge clk);
        oe = 1'b0;
        repeat (100) @(negedge clk);
        oe = 1'b1;
        on_model += 100;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 32; i++) shift_px(6'($urandom));
        do_latch(3'd4, 1'b0, 6'b0);
        read_row(4);

        // Reset mid-row, then a clean full row
        for (int i = 0; i < 10; i++) shift_px(6'($urandom));
        @(negedge clk);
        check("pending_commits_before_reset", cq.size(), 0);
        reset = 1'b1;
        sclk  = 1'b0;
        lat   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("midreset");
        for (int i = 0; i < 32; i++) shift_px(6'($urandom));
        do_latch(3'd6, 1'b0, 6'b0);
        read_row(6);
        read_row(14);
        read_row(3);

        repeat (10) @(negedge clk);
        check("commit_queue_empty", cq.size(), 0);
        check("read_queue_empty",   rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
